// File: rtl/ins_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot-time instruction loader.
// The loader uses the master modport; the stream source / memory side uses slave.
interface ins_loader_if #(
    parameter int ADDR_W = 8
);
    // Stream handshake: a byte moves on a rising CLK edge only when BYTE_VLD and
    // BYTE_RDY are both high; BYTE_RDY never depends combinationally on BYTE_VLD.
    logic [7:0]        BYTE_IN;
    logic              BYTE_VLD;
    logic              BYTE_RDY;
    logic              WE;
    logic [ADDR_W-1:0] W_ADDR;
    logic [31:0]       W_Ins;

    modport master (
        input  BYTE_IN,
        input  BYTE_VLD,
        output BYTE_RDY,
        output WE,
        output W_ADDR,
        output W_Ins
    );

    modport slave (
        output BYTE_IN,
        output BYTE_VLD,
        input  BYTE_RDY,
        input  WE,
        input  W_ADDR,
        input  W_Ins
    );
endinterface

// File: rtl/ins_loader.sv
// Boot loader: parses a counted big-endian byte stream into 32-bit words for the core's
// instruction memory. Define INS_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module ins_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    ins_loader_if.master bus,
    output logic         CPU_RUN,
    output logic         DONE,
    output logic         ERR,
    output logic [2:0]   dbg_state
);

    localparam int HDR_BYTES = CNT_W / 8;
    localparam int CMP_W     = ((CNT_W > ADDR_W) ? CNT_W : ADDR_W) + 2;
    localparam logic [CMP_W-1:0]  CAPACITY = {{(CMP_W-1){1'b0}}, 1'b1} << ADDR_W;
    localparam logic [ADDR_W:0]   WIDX_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [2:0]        HDR_LAST = 3'(HDR_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4,
        S_FAIL  = 3'd5
`ifdef INS_LOADER_CHECKSUM_EN
        , S_CHK = 3'd6
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [ADDR_W:0]   widx_q, widx_d;
    logic [23:0]       asm_q, asm_d;
    logic              rdy_q, rdy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wins_q, wins_d;
    logic              run_q, run_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef INS_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic              accept;
    logic [CNT_W-1:0]  n_shift;
    logic [ADDR_W:0]   widx_inc;
    logic              to_end;
    logic              to_fin;
    logic              to_fail;

    assign accept   = bus.BYTE_VLD & rdy_q;
    assign n_shift  = (n_q << 8) | CNT_W'(bus.BYTE_IN);
    assign widx_inc = widx_q + WIDX_ONE;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        bcnt_d  = bcnt_q;
        widx_d  = widx_q;
        asm_d   = asm_q;
        rdy_d   = rdy_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wins_d  = wins_q;
        run_d   = run_q;
        done_d  = done_q;
        err_d   = err_q;
        to_end  = 1'b0;
        to_fin  = 1'b0;
        to_fail = 1'b0;
`ifdef INS_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif

        case (state_q)
            S_IDLE, S_FIN, S_FAIL: begin
                if (START) begin
                    state_d = S_HDR;
                    rdy_d   = 1'b1;
                    run_d   = 1'b0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    bcnt_d  = 3'd0;
                    n_d     = '0;
`ifdef INS_LOADER_CHECKSUM_EN
                    xor_d   = 8'h00;
`endif
                end
            end
            S_HDR: begin
                if (accept) begin
                    n_d    = n_shift;
                    bcnt_d = bcnt_q + 3'd1;
`ifdef INS_LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ bus.BYTE_IN;
`endif
                    if (bcnt_q == HDR_LAST) begin
                        bcnt_d = 3'd0;
                        // Counts above capacity are refused before any write so the index cannot wrap.
                        if (n_shift == '0) begin
                            to_end = 1'b1;
                        end else if (CMP_W'(n_shift) > CAPACITY) begin
                            to_fail = 1'b1;
                        end else begin
                            state_d = S_DATA;
                            widx_d  = '0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d  = {asm_q[15:0], bus.BYTE_IN};
                    bcnt_d = bcnt_q + 3'd1;
`ifdef INS_LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ bus.BYTE_IN;
`endif
                    if (bcnt_q == 3'd3) begin
                        bcnt_d  = 3'd0;
                        state_d = S_WRITE;
                        rdy_d   = 1'b0;
                        we_d    = 1'b1;
                        wins_d  = {asm_q, bus.BYTE_IN};
                        waddr_d = widx_q[ADDR_W-1:0];
                    end
                end
            end
            S_WRITE: begin
                widx_d = widx_inc;
                if (CMP_W'(widx_inc) == CMP_W'(n_q)) begin
                    to_end = 1'b1;
                end else begin
                    state_d = S_DATA;
                    rdy_d   = 1'b1;
                end
            end
`ifdef INS_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    if ((xor_q ^ bus.BYTE_IN) == 8'h00) begin
                        to_fin = 1'b1;
                    end else begin
                        to_fail = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                rdy_d   = 1'b0;
            end
        endcase

        // End of payload: either wait for the checksum byte or finish straight away.
`ifdef INS_LOADER_CHECKSUM_EN
        if (to_end) begin
            state_d = S_CHK;
            rdy_d   = 1'b1;
        end
`else
        if (to_end) begin
            to_fin = 1'b1;
        end
`endif
        if (to_fin) begin
            state_d = S_FIN;
            rdy_d   = 1'b0;
            done_d  = 1'b1;
            run_d   = 1'b1;
        end
        if (to_fail) begin
            state_d = S_FAIL;
            rdy_d   = 1'b0;
            err_d   = 1'b1;
            run_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            bcnt_q  <= 3'd0;
            widx_q  <= '0;
            asm_q   <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wins_q  <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef INS_LOADER_CHECKSUM_EN
            xor_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            bcnt_q  <= bcnt_d;
            widx_q  <= widx_d;
            asm_q   <= asm_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wins_q  <= wins_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef INS_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign bus.BYTE_RDY = rdy_q;
    assign bus.WE       = we_q;
    assign bus.W_ADDR   = waddr_q;
    assign bus.W_Ins    = wins_q;
    assign CPU_RUN      = run_q;
    assign DONE         = done_q;
    assign ERR          = err_q;
    assign dbg_state    = state_q;

    // The write strobe is a single-cycle pulse during which no byte is taken.
    a_we_pulse: assert property (@(posedge CLK) disable iff (!RST) we_q |=> !we_q);
    a_we_no_rdy: assert property (@(posedge CLK) disable iff (!RST) we_q |-> !rdy_q);
    a_done_err: assert property (@(posedge CLK) disable iff (!RST) !(done_q && err_q));
    a_run_done: assert property (@(posedge CLK) disable iff (!RST) run_q == done_q);

endmodule

// File: tb/tb_ins_loader.sv
// Self-checking bench for ins_loader: randomized streams against a list-based write model.
module tb_ins_loader;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       CPU_RUN, DONE, ERR;
    logic [2:0] dbg_state;

    ins_loader_if #(.ADDR_W(ADDR_W)) bus ();

    ins_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .bus       (bus),
        .CPU_RUN   (CPU_RUN),
        .DONE      (DONE),
        .ERR       (ERR),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int we_pulses = 0;
    logic [31:0]        stim_words[$];
    logic [ADDR_W+31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (bus.WE === 1'b1) we_pulses++;
    end

    function automatic int gap_of(input int max_gap);
        return (max_gap == 0) ? 0 : int'($urandom_range(1, max_gap));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        @(negedge CLK);
        if (gap > 0) begin
            bus.BYTE_VLD = 1'b0;
            repeat (gap) @(negedge CLK);
        end
        bus.BYTE_IN  = b;
        bus.BYTE_VLD = 1'b1;
        t = 0;
        while (bus.BYTE_RDY !== 1'b1) begin
            if (t == 200) begin
                check("byte_timeout", 64'd0, 64'd1);
                bus.BYTE_VLD = 1'b0;
                return;
            end
            t++;
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        bus.BYTE_VLD = 1'b0;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    // Model: a count within capacity yields writes (i, word i); above capacity, none and ERR.
    task automatic do_load(input int n, input int max_gap, input bit bad_chk, input int start_at);
        logic [CNT_W-1:0]   nn;
        logic [7:0]         b;
        logic [7:0]         xacc;
        logic [ADDR_W+31:0] e;
        bit                 ok;
        bit                 exp_done;
        int                 base;
        nn = CNT_W'(n);
        ok = (n <= (1 << ADDR_W));
        exp_done = ok;
`ifdef INS_LOADER_CHECKSUM_EN
        if (bad_chk) exp_done = 1'b0;
`endif
        exp_q = {};
        if (ok) begin
            for (int i = 0; i < n; i++) exp_q.push_back({ADDR_W'(i), stim_words[i]});
        end
        base = we_pulses;
        @(negedge CLK);
        pulse_start();
        @(negedge CLK);
        check("start_rdy", 64'(bus.BYTE_RDY), 64'd1);
        check("start_flags", 64'({CPU_RUN, DONE, ERR}), 64'd0);
        xacc = 8'h00;
        for (int h = CNT_W/8 - 1; h >= 0; h--) begin
            b = nn[8*h +: 8];
            send_byte(b, gap_of(max_gap));
            xacc = xacc ^ b;
        end
        if (ok) begin
            for (int w = 0; w < n; w++) begin
                for (int k = 3; k >= 0; k--) begin
                    b = stim_words[w][8*k +: 8];
                    send_byte(b, gap_of(max_gap));
                    xacc = xacc ^ b;
                    if (w == start_at && k == 3) pulse_start();
                end
                @(negedge CLK);
                e = exp_q.pop_front();
                check("we", 64'(bus.WE), 64'd1);
                check("w_addr", 64'(bus.W_ADDR), 64'(e[ADDR_W+31:32]));
                check("w_ins", 64'(bus.W_Ins), 64'(e[31:0]));
                check("rdy_in_write", 64'(bus.BYTE_RDY), 64'd0);
            end
`ifdef INS_LOADER_CHECKSUM_EN
            send_byte(xacc ^ (bad_chk ? 8'h01 : 8'h00), gap_of(max_gap));
`endif
        end
        bus.BYTE_VLD = 1'b0;
        @(negedge CLK);
        check("done", 64'(DONE), 64'(exp_done));
        check("err", 64'(ERR), 64'(!exp_done));
        check("cpu_run", 64'(CPU_RUN), 64'(exp_done));
        check("rdy_end", 64'(bus.BYTE_RDY), 64'd0);
        check("we_count", 64'(we_pulses - base), ok ? 64'(n) : 64'd0);
        check("exp_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge CLK);
        check("sticky", 64'({DONE, ERR}), 64'({exp_done, !exp_done}));
    endtask

    task automatic rand_words(input int n);
        stim_words = {};
        for (int i = 0; i < n; i++) stim_words.push_back($urandom);
    endtask

    initial begin
        int base;
        logic [44:0] zeros;
        bus.BYTE_IN  = 8'h00;
        bus.BYTE_VLD = 1'b0;
        zeros = '0;

        // Reset then idle, with stray valid pulses
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("in_reset", 64'({bus.BYTE_RDY, bus.WE, CPU_RUN, DONE, ERR, bus.W_ADDR, bus.W_Ins}), 64'(zeros));
        RST = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.BYTE_VLD = 1'($urandom_range(0, 1));
            bus.BYTE_IN  = 8'($urandom);
            @(negedge CLK);
            check("idle", 64'({bus.BYTE_RDY, bus.WE, CPU_RUN, DONE, ERR, bus.W_ADDR, bus.W_Ins}), 64'(zeros));
        end
        bus.BYTE_VLD = 1'b0;

        // Basic two-word load, valid held high, then with bubbles
        stim_words = {32'h20080005, 32'hAC080000};
        do_load(2, 0, 1'b0, -1);
        do_load(2, 5, 1'b0, -1);

        // Random programs
        for (int r = 0; r < 3; r++) begin
            int n;
            n = int'($urandom_range(1, 10));
            rand_words(n);
            do_load(n, int'($urandom_range(0, 3)), 1'b0, -1);
        end

        // Boundaries: empty, one over capacity, exactly full
        stim_words = {};
        do_load(0, 0, 1'b0, -1);
        do_load(257, 2, 1'b0, -1);
        rand_words(256);
        do_load(256, 0, 1'b0, -1);

        // START during DATA is ignored
        rand_words(3);
        do_load(3, 1, 1'b0, 1);

        // Reset after six data bytes, then a clean reload
        rand_words(3);
        @(negedge CLK);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        for (int k = 0; k < 6; k++) send_byte(stim_words[k/4][8*(3 - k%4) +: 8], 0);
        RST = 1'b0;
        #1;
        check("rst_async", 64'({bus.BYTE_RDY, bus.WE, CPU_RUN, DONE, ERR, bus.W_ADDR, bus.W_Ins}), 64'(zeros));
        base = we_pulses;
        repeat (5) @(negedge CLK);
        check("rst_hold", 64'({bus.BYTE_RDY, bus.WE, CPU_RUN, DONE, ERR, bus.W_ADDR, bus.W_Ins}), 64'(zeros));
        check("rst_no_we", 64'(we_pulses - base), 64'd0);
        RST = 1'b1;
        bus.BYTE_VLD = 1'b0;
        rand_words(2);
        do_load(2, 2, 1'b0, -1);

`ifdef INS_LOADER_CHECKSUM_EN
        stim_words = {32'h12345678};
        do_load(1, 0, 1'b0, -1);
        do_load(1, 0, 1'b1, -1);
        check("chk_last_addr", 64'(bus.W_ADDR), 64'd0);
        check("chk_last_ins", 64'(bus.W_Ins), 64'h12345678);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
